// File: rtl/stall_sequencer.sv
// rtl/stall_sequencer.sv - pipeline stall/flush sequencer with boot, bubble and freeze handling
module stall_sequencer #(
  parameter int unsigned LOAD_BUBBLES      = 1,
  parameter int unsigned BR_ALU_BUBBLES    = 1,
  parameter int unsigned BR_LOAD_E_BUBBLES = 2,
  parameter int unsigned BR_LOAD_M_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        br_dep_alu,
  input  logic        br_dep_load_e,
  input  logic        br_dep_load_m,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_next;
  logic [15:0] r_stall_cycles;
  logic        w_freeze;
  logic        w_hazard;
  logic [1:0]  w_bubbles;

  assign w_freeze = mem_req & ~mem_ready;
  assign w_hazard = load_use | br_dep_alu | br_dep_load_e | br_dep_load_m;

  // Bubble count is the worst case among all hazards raised this cycle.
  always_comb begin
    w_bubbles = 2'd0;
    if (load_use      && 2'(LOAD_BUBBLES)      > w_bubbles) w_bubbles = 2'(LOAD_BUBBLES);
    if (br_dep_alu    && 2'(BR_ALU_BUBBLES)    > w_bubbles) w_bubbles = 2'(BR_ALU_BUBBLES);
    if (br_dep_load_e && 2'(BR_LOAD_E_BUBBLES) > w_bubbles) w_bubbles = 2'(BR_LOAD_E_BUBBLES);
    if (br_dep_load_m && 2'(BR_LOAD_M_BUBBLES) > w_bubbles) w_bubbles = 2'(BR_LOAD_M_BUBBLES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= BOOT;
      r_cnt          <= 2'd0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (!pc_en && r_stall_cycles != 16'hFFFF)
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;

    if (rst || r_state == BOOT || (r_state != RUN && r_state != STALL)) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      w_state_next = RUN;
      w_cnt_next   = 2'd0;
    end else if (w_freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (r_state == STALL || w_hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      if (r_state == STALL) begin
        // A zero count cannot occur in STALL; treat it like the last bubble.
        if (r_cnt <= 2'd1) begin
          w_cnt_next   = 2'd0;
          w_state_next = RUN;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end else if (w_bubbles > 2'd1) begin
        w_cnt_next   = w_bubbles - 2'd1;
        w_state_next = STALL;
      end
    end else begin
      ifid_flush = branch_taken | jump;
    end
  end

  assign ctrl_state   = r_state;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_stall_sequencer.sv
// tb/tb_stall_sequencer.sv - directed self-checking bench for stall_sequencer
module tb_stall_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_use, br_dep_alu, br_dep_load_e, br_dep_load_m;
  logic        branch_taken, jump, mem_req, mem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cycles;

  int tests  = 0;
  int failed = 0;

  // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en}
  localparam logic [5:0] O_BOOT   = 6'b001111;
  localparam logic [5:0] O_NORM   = 6'b110011;
  localparam logic [5:0] O_NORMFL = 6'b111011;
  localparam logic [5:0] O_STALL  = 6'b000111;
  localparam logic [5:0] O_FREEZE = 6'b000000;

  stall_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .load_use     (load_use),
    .br_dep_alu   (br_dep_alu),
    .br_dep_load_e(br_dep_load_e),
    .br_dep_load_m(br_dep_load_m),
    .branch_taken (branch_taken),
    .jump         (jump),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ctrl_state   (ctrl_state),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [5:0] exp);
    #1;
    check(tag, {10'd0, pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en}, {10'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_use = 0; br_dep_alu = 0; br_dep_load_e = 0; br_dep_load_m = 0;
    branch_taken = 0; jump = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    chk_outs("reset_outs", O_BOOT);
    check("reset_state", 16'(ctrl_state), 16'd0);
    check("reset_sc", stall_cycles, 16'd0);

    rst = 1'b0;
    chk_outs("boot_outs", O_BOOT);
    check("boot_state", 16'(ctrl_state), 16'd0);
    step();
    chk_outs("run_outs", O_NORM);
    check("run_state", 16'(ctrl_state), 16'd1);
    check("boot_sc", stall_cycles, 16'd1);

    load_use = 1;
    chk_outs("lu_stall", O_STALL);
    step();
    load_use = 0;
    chk_outs("lu_after", O_NORM);
    check("lu_state", 16'(ctrl_state), 16'd1);
    check("lu_sc", stall_cycles, 16'd2);

    br_dep_load_e = 1;
    chk_outs("ble_t0", O_STALL);
    step();
    chk_outs("ble_t1", O_STALL);
    check("ble_t1_state", 16'(ctrl_state), 16'd2);
    step();
    chk_outs("ble_t2_held", O_STALL);
    br_dep_load_e = 0;
    chk_outs("ble_t2_drop", O_NORM);
    check("ble_sc", stall_cycles, 16'd4);
    step();

    br_dep_load_e = 1;
    #1;
    step();
    br_dep_load_e = 0;
    mem_req = 1;
    check("frz_state", 16'(ctrl_state), 16'd2);
    for (int i = 0; i < 3; i++) begin
      chk_outs("frz_stall", O_FREEZE);
      step();
      check("frz_hold", 16'(ctrl_state), 16'd2);
    end
    mem_req = 0;
    chk_outs("frz_bubble", O_STALL);
    step();
    check("frz_run", 16'(ctrl_state), 16'd1);
    check("frz_sc", stall_cycles, 16'd9);

    branch_taken = 1; br_dep_alu = 1;
    chk_outs("br_alu", O_STALL);
    step();
    br_dep_alu = 0;
    chk_outs("br_taken", O_NORMFL);
    check("br_sc", stall_cycles, 16'd10);
    branch_taken = 0; jump = 1;
    chk_outs("jump", O_NORMFL);
    step();
    jump = 0;

    mem_req = 1; load_use = 1; jump = 1;
    chk_outs("run_frz", O_FREEZE);
    step();
    check("run_frz_state", 16'(ctrl_state), 16'd1);
    check("run_frz_sc", stall_cycles, 16'd11);
    clear_inputs();
    chk_outs("run_frz_off", O_NORM);
    step();

    load_use = 1; br_dep_load_e = 1;
    chk_outs("max_n", O_STALL);
    step();
    clear_inputs();
    check("max_n_state", 16'(ctrl_state), 16'd2);
    chk_outs("max_n_bub", O_STALL);
    step();
    check("max_n_run", 16'(ctrl_state), 16'd1);
    check("max_n_sc", stall_cycles, 16'd13);

    br_dep_load_e = 1;
    #1;
    step();
    clear_inputs();
    rst = 1;
    chk_outs("rst_mid_outs", O_BOOT);
    step();
    check("rst_mid_state", 16'(ctrl_state), 16'd0);
    check("rst_mid_sc", stall_cycles, 16'd0);
    rst = 0;
    step();
    check("rst_rel_state", 16'(ctrl_state), 16'd1);
    check("rst_rel_sc", stall_cycles, 16'd1);

    mem_req = 1;
    repeat (65540) step();
    check("sat_sc", stall_cycles, 16'hFFFF);
    check("sat_state", 16'(ctrl_state), 16'd1);
    rst = 1;
    step();
    check("sat_rst_sc", stall_cycles, 16'd0);
    check("sat_rst_state", 16'(ctrl_state), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
